// File: rtl/window_dma_responder.sv
// DMA command responder: serves window reads, single-word writes and filter/bias
// streaming between the layer controller, a single-port RAM and the filter buffer.
//
// state | meaning
// IDLE  | waiting for start; command fields latched on acceptance
// ISSUE | one RAM access per cycle
// DRAIN | last read returns; captured into the window or forwarded
// DONE  | finish high until start is seen low
module window_dma_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WIN    = 5,
    parameter int IDX_W  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       finish,
    input  logic [1:0]                 cmd_mode,
    input  logic [ADDR_W-1:0]          start_address,
    input  logic [ADDR_W-1:0]          offset,
    input  logic [IDX_W-1:0]           num,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [WIN*WIN*DATA_W-1:0]  win_data,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       fb_we,
    output logic                       fb_bias,
    output logic [IDX_W-1:0]           fb_index,
    output logic [2:0]                 fb_row,
    output logic [2:0]                 fb_col,
    output logic [DATA_W-1:0]          fb_data
);

    localparam int         NWORDS  = WIN * WIN;
    localparam int         PW      = $clog2(NWORDS);
    localparam logic [2:0] LAST_RC = 3'(WIN - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              r_state;
    state_t              w_next;

    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_row_base;
    logic [ADDR_W-1:0]   r_offset;
    logic [IDX_W-1:0]    r_num;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_row;
    logic [2:0]          r_col;
    logic [IDX_W-1:0]    r_idx;
    logic [PW-1:0]       r_pos;

    logic                r_rd_vld;
    logic [2:0]          r_row_q;
    logic [2:0]          r_col_q;
    logic [IDX_W-1:0]    r_idx_q;
    logic [PW-1:0]       r_pos_q;
    logic [DATA_W-1:0]   r_win [NWORDS];

    logic                w_accept;
    logic                w_issue;
    logic                w_rc_last;
    logic                w_last;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_issue   = (r_state == ISSUE);
    assign w_rc_last = (r_row == LAST_RC) && (r_col == LAST_RC);

    always_comb begin
        w_last = 1'b0;
        case (r_mode)
            2'd0:    w_last = w_rc_last;
            2'd1:    w_last = 1'b1;
            2'd2:    w_last = (r_idx == r_num - IDX_W'(1)) && w_rc_last;
            default: w_last = (r_idx == r_num - IDX_W'(1));
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                // zero-length filter/bias loads complete without touching the RAM
                if (start) w_next = (cmd_mode[1] && (num == '0)) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (w_last) w_next = (r_mode == 2'd1) ? DONE : DRAIN;
            end
            DRAIN:   w_next = DONE;
            DONE: begin
                if (!start) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= '0;
            r_addr     <= '0;
            r_row_base <= '0;
            r_offset   <= '0;
            r_num      <= '0;
            r_wdata    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_idx      <= '0;
            r_pos      <= '0;
        end else if (w_accept) begin
            r_mode     <= cmd_mode;
            r_addr     <= start_address;
            r_row_base <= start_address;
            r_offset   <= offset;
            r_num      <= num;
            r_wdata    <= wr_data;
            r_row      <= '0;
            r_col      <= '0;
            r_idx      <= '0;
            r_pos      <= '0;
        end else if (w_issue) begin
            case (r_mode)
                2'd0: begin
                    r_pos <= r_pos + PW'(1);
                    if (r_col == LAST_RC) begin
                        r_col      <= '0;
                        r_row      <= r_row + 3'd1;
                        r_row_base <= r_row_base + r_offset;
                        r_addr     <= r_row_base + r_offset;
                    end else begin
                        r_col  <= r_col + 3'd1;
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                2'd2: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (r_col == LAST_RC) begin
                        r_col <= '0;
                        if (r_row == LAST_RC) begin
                            r_row <= '0;
                            r_idx <= r_idx + IDX_W'(1);
                        end else begin
                            r_row <= r_row + 3'd1;
                        end
                    end else begin
                        r_col <= r_col + 3'd1;
                    end
                end
                2'd3: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_idx  <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Read-return pipeline: tags travel one cycle behind the issued address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_vld <= 1'b0;
            r_row_q  <= '0;
            r_col_q  <= '0;
            r_idx_q  <= '0;
            r_pos_q  <= '0;
        end else begin
            r_rd_vld <= w_issue && (r_mode != 2'd1);
            if (w_issue) begin
                r_row_q <= r_row;
                r_col_q <= r_col;
                r_idx_q <= r_idx;
                r_pos_q <= r_pos;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NWORDS; i++) r_win[i] <= '0;
        end else if (r_rd_vld && (r_mode == 2'd0)) begin
            for (int i = 0; i < NWORDS; i++) begin
                if (r_pos_q == PW'(i)) r_win[i] <= mem_rdata;
            end
        end
    end

    for (genvar g = 0; g < NWORDS; g++) begin : g_pack
        assign win_data[g*DATA_W +: DATA_W] = r_win[g];
    end

    assign finish    = (r_state == DONE);
    assign mem_en    = w_issue;
    assign mem_we    = w_issue && (r_mode == 2'd1);
    assign mem_addr  = w_issue ? r_addr : '0;
    assign mem_wdata = mem_we ? r_wdata : '0;

    assign fb_we     = r_rd_vld && r_mode[1];
    assign fb_bias   = fb_we && r_mode[0];
    assign fb_index  = fb_we ? r_idx_q : '0;
    assign fb_row    = fb_we ? r_row_q : '0;
    assign fb_col    = fb_we ? r_col_q : '0;
    assign fb_data   = fb_we ? mem_rdata : '0;

endmodule

// File: tb/tb_window_dma_responder.sv
// Bench for window_dma_responder: behavioural RAM, per-cycle expectations derived
// from the command rules, pinned literal cases, then randomized commands.
module tb_window_dma_responder;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WIN = 5;
    localparam int IW = 12;
    localparam int NW = WIN * WIN;
    localparam int WB = NW * DW;

    logic           clk;
    logic           reset;
    logic           start;
    logic           finish;
    logic [1:0]     cmd_mode;
    logic [AW-1:0]  start_address;
    logic [AW-1:0]  offset;
    logic [IW-1:0]  num;
    logic [DW-1:0]  wr_data;
    logic [WB-1:0]  win_data;
    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;
    logic           fb_we;
    logic           fb_bias;
    logic [IW-1:0]  fb_index;
    logic [2:0]     fb_row;
    logic [2:0]     fb_col;
    logic [DW-1:0]  fb_data;

    window_dma_responder #(.ADDR_W(AW), .DATA_W(DW), .WIN(WIN), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .cmd_mode(cmd_mode), .start_address(start_address), .offset(offset),
        .num(num), .wr_data(wr_data), .win_data(win_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fb_we(fb_we), .fb_bias(fb_bias), .fb_index(fb_index),
        .fb_row(fb_row), .fb_col(fb_col), .fb_data(fb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cur_cyc = 0;

    // RAM: unwritten words read back as (address ^ key); written words are remembered.
    logic [15:0] key = 16'h0000;
    logic [DW-1:0] ram_w [65536];
    logic          ram_v [65536];
    logic          ram_init = 1'b0;

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        if (ram_init && ram_v[a]) return ram_w[a];
        return a ^ key;
    endfunction

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int a = 0; a < 65536; a++) ram_v[a] <= 1'b0;
            ram_init <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram_w[mem_addr] <= mem_wdata;
            ram_v[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we) mem_rdata <= ram_rd(mem_addr);
        else                   mem_rdata <= DW'($urandom);
    end

    logic [DW-1:0] exp_win [NW];
    int lg_addr  [256];
    int lg_fbidx [256];
    int lg_fbrow [256];
    int lg_fbcol [256];
    int lg_fbdat [256];
    int fin_cyc;
    int n_fb;
    int n_mem;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cur_cyc, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cur_cyc, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] win_addr(input logic [AW-1:0] sa, input logic [AW-1:0] off,
                                               input int k);
        return sa + off * AW'(k / WIN) + AW'(k % WIN);
    endfunction

    // drop = cycle on whose negedge start is released early; 0 = hold until finish.
    task automatic run_cmd(input logic [1:0] m, input logic [AW-1:0] sa, input logic [AW-1:0] off,
                           input logic [IW-1:0] nm, input logic [DW-1:0] wd, input int drop_in);
        int L, I, last, k, drop;
        logic [DW-1:0] nw [NW];
        logic [WB-1:0] ew;
        logic [AW-1:0] a;
        bit en, fbwe, fin;
        case (m)
            2'd0:    I = NW;
            2'd1:    I = 1;
            2'd2:    I = int'(nm) * NW;
            default: I = int'(nm);
        endcase
        L = (I == 0) ? 1 : ((m == 2'd1) ? 2 : I + 2);
        drop = (drop_in >= L) ? 0 : drop_in;
        for (int e = 0; e < NW; e++) nw[e] = ram_rd(win_addr(sa, off, e));
        fin_cyc = -1;
        n_fb = 0;
        n_mem = 0;
        @(negedge clk);
        start = 1'b1; cmd_mode = m; start_address = sa; offset = off; num = nm; wr_data = wd;
        @(posedge clk);
        #1;
        cmd_mode = 2'($urandom); start_address = AW'($urandom); offset = AW'($urandom);
        num = IW'($urandom); wr_data = DW'($urandom);
        last = (drop > 0) ? L + 1 : L + 3;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            cur_cyc = n;
            en = (n <= I);
            chk("mem_en", 32'(mem_en), 32'(en));
            chk("mem_we", 32'(mem_we), 32'(en && m == 2'd1));
            if (en) begin
                k = n - 1;
                a = (m == 2'd0) ? win_addr(sa, off, k) : ((m == 2'd1) ? sa : sa + AW'(k));
                chk("mem_addr", 32'(mem_addr), 32'(a));
                if (m == 2'd1) chk("mem_wdata", 32'(mem_wdata), 32'(wd));
            end
            fbwe = m[1] && (n >= 2) && (n <= I + 1);
            chk("fb_we", 32'(fb_we), 32'(fbwe));
            if (fbwe) begin
                k = n - 2;
                chk("fb_bias", 32'(fb_bias), 32'(m[0]));
                chk("fb_index", 32'(fb_index), (m == 2'd3) ? 32'(k) : 32'(k / NW));
                chk("fb_row", 32'(fb_row), (m == 2'd3) ? 32'd0 : 32'((k % NW) / WIN));
                chk("fb_col", 32'(fb_col), (m == 2'd3) ? 32'd0 : 32'(k % WIN));
                chk("fb_data", 32'(fb_data), 32'(ram_rd(sa + AW'(k))));
            end
            fin = (drop > 0) ? (n == L) : (n >= L && n <= L + 2);
            chk("finish", 32'(finish), 32'(fin));
            for (int e = 0; e < NW; e++)
                ew[e*DW +: DW] = (m == 2'd0 && e <= n - 3) ? nw[e] : exp_win[e];
            chkw("win_data", win_data, ew);
            chk("no_x", 32'($isunknown({finish, win_data, mem_en, mem_we, mem_addr, mem_wdata,
                                        fb_we, fb_bias, fb_index, fb_row, fb_col, fb_data})), 32'd0);
            if (n < 256) begin
                lg_addr[n]  = int'(mem_addr);
                lg_fbidx[n] = int'(fb_index);
                lg_fbrow[n] = int'(fb_row);
                lg_fbcol[n] = int'(fb_col);
                lg_fbdat[n] = int'(fb_data);
            end
            if (finish && fin_cyc < 0) fin_cyc = n;
            n_fb  += int'(fb_we);
            n_mem += int'(mem_en);
            if (drop > 0 && n == drop) start = 1'b0;
            if (drop == 0 && n == L + 2) start = 1'b0;
        end
        if (m == 2'd0) for (int e = 0; e < NW; e++) exp_win[e] = nw[e];
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, 32'(|{finish, mem_en, mem_we, mem_addr, mem_wdata, fb_we, fb_bias,
                      fb_index, fb_row, fb_col, fb_data}), 32'd0);
        chkw({nm, "_win"}, win_data, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [1:0] m;
        logic [IW-1:0] nm;
        reset = 1'b0; start = 1'b0; cmd_mode = '0; start_address = '0;
        offset = '0; num = '0; wr_data = '0;
        for (int e = 0; e < NW; e++) exp_win[e] = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outs");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(2'd0, 16'd100, 16'd32, '0, '0, 0);
        chk("t0_finish_cycle", 32'(fin_cyc), 32'd27);
        chk("t0_addr_c1", 32'(lg_addr[1]), 32'd100);
        chk("t0_addr_c6", 32'(lg_addr[6]), 32'd132);
        chk("t0_addr_c25", 32'(lg_addr[25]), 32'd232);
        chk("t0_win44", 32'(win_data[24*DW +: DW]), 32'd232);

        run_cmd(2'd1, 16'hFFFF, '0, '0, 16'h1234, 0);
        chk("t1_finish_cycle", 32'(fin_cyc), 32'd2);
        chk("t1_addr", 32'(lg_addr[1]), 32'h0000FFFF);
        chk("t1_ram", 32'(ram_rd(16'hFFFF)), 32'h00001234);

        run_cmd(2'd2, 16'd0, '0, 12'd2, '0, 0);
        chk("t2_finish_cycle", 32'(fin_cyc), 32'd52);
        chk("t2_fb_pulses", 32'(n_fb), 32'd50);
        chk("t2_w27_index", 32'(lg_fbidx[29]), 32'd1);
        chk("t2_w27_row", 32'(lg_fbrow[29]), 32'd0);
        chk("t2_w27_col", 32'(lg_fbcol[29]), 32'd2);
        chk("t2_w27_data", 32'(lg_fbdat[29]), 32'd27);

        run_cmd(2'd3, 16'd50550, '0, 12'd6, '0, 0);
        chk("t3_finish_cycle", 32'(fin_cyc), 32'd8);
        chk("t3_fb_pulses", 32'(n_fb), 32'd6);
        chk("t3_last_index", 32'(lg_fbidx[7]), 32'd5);

        run_cmd(2'd3, 16'd50550, '0, 12'd0, '0, 0);
        chk("t4_finish_cycle", 32'(fin_cyc), 32'd1);
        chk("t4_fb_pulses", 32'(n_fb), 32'd0);
        chk("t4_mem_pulses", 32'(n_mem), 32'd0);

        run_cmd(2'd0, 16'hFFFE, 16'hFFF0, '0, '0, 0);
        chk("t5_addr_c1", 32'(lg_addr[1]), 32'h0000FFFE);
        chk("t5_addr_c3", 32'(lg_addr[3]), 32'h00000000);
        chk("t5_addr_c6", 32'(lg_addr[6]), 32'h0000FFEE);

        run_cmd(2'd0, 16'd300, 16'd7, '0, '0, 5);
        chk("t6_finish_cycle", 32'(fin_cyc), 32'd27);

        // reset in the middle of a filter load
        @(negedge clk);
        start = 1'b1; cmd_mode = 2'd2; start_address = '0; num = 12'd2;
        @(posedge clk);
        repeat (10) @(negedge clk);
        cur_cyc = 10;
        chk("t7_busy_before_reset", 32'(fb_we), 32'd1);
        #2 reset = 1'b0;
        #1 chk_all_zero("t7_reset_outs");
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero("t7_quiet");
        end
        reset = 1'b1;
        for (int e = 0; e < NW; e++) exp_win[e] = '0;
        run_cmd(2'd1, 16'h0042, '0, '0, 16'hBEEF, 0);
        chk("t7_finish_cycle", 32'(fin_cyc), 32'd2);

        key = 16'hA5C3;
        for (int t = 0; t < 40; t++) begin
            m  = 2'($urandom_range(0, 3));
            nm = (m == 2'd2) ? IW'($urandom_range(0, 3)) : IW'($urandom_range(0, 12));
            run_cmd(m, AW'($urandom), AW'($urandom), nm, DW'($urandom),
                    ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
